prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/loader_chksum.sv | 31 +++
 rtl/prog_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and size defaults for prog_loader (PROG_LOADER_CHKSUM_EN adds ST_CHK)
package prog_loader_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int MAX_LEN    = 32;

  // Load sequencer states; CHK exists only when the checksum trailer is enabled.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
`ifdef PROG_LOADER_CHKSUM_EN
    ,
    ST_CHK  = 3'd3
`endif
  } state_t;

endpackage

// File: rtl/loader_chksum.sv
// rtl/loader_chksum.sv - modulo-2^DATA_W payload sum with clear, add and compare (used under PROG_LOADER_CHKSUM_EN)
module loader_chksum
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              match_o
);

  logic [DATA_W-1:0] sum_q;

  // Running sum of accepted payload bytes; clear wins over add.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
    end else if (add_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  // The trailer byte is compared against the completed sum while it is presented.
  assign match_o = (sum_q == data_i);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - length-prefixed byte stream to program memory loader; checksum trailer with PROG_LOADER_CHKSUM_EN
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [DATA_W-1:0] MAX_LEN_W = DATA_W'(MAX_LEN);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] last_idx_q;
  logic              accept;
  logic              len_bad;
  logic              last_byte;
  logic              restartable;

  assign accept      = valid_i & ready_o;
  assign len_bad     = (data_i == '0) || (data_i > MAX_LEN_W);
  assign last_byte   = (cnt_q == last_idx_q);
  assign restartable = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);

`ifdef PROG_LOADER_CHKSUM_EN
  logic sum_clr;
  logic sum_add;
  logic sum_match;

  assign sum_clr = start_i & restartable;
  assign sum_add = accept & (state_q == ST_DATA);

  loader_chksum #(
    .DATA_W (DATA_W)
  ) u_chksum (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (sum_clr),
    .add_i   (sum_add),
    .data_i  (data_i),
    .match_o (sum_match)
  );
`else
  // Set after the last payload byte so DATA lingers (not ready) for the final write cycle.
  logic flush_q;
`endif

  // Load sequencer with registered handshake, memory strobe and status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_idx_q <= '0;
      ready_o    <= 1'b0;
      mem_wen_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      cpu_rst_o  <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
`ifndef PROG_LOADER_CHKSUM_EN
      flush_q    <= 1'b0;
`endif
    end else begin
      mem_wen_o <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            state_q   <= ST_LEN;
            ready_o   <= 1'b1;
            cnt_q     <= '0;
            cpu_rst_o <= 1'b1;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
          end
        end
        ST_LEN: begin
          if (accept) begin
            if (len_bad) begin
              state_q <= ST_ERR;
              ready_o <= 1'b0;
              err_o   <= 1'b1;
            end else begin
              state_q    <= ST_DATA;
              last_idx_q <= ADDR_W'(data_i - 1'b1);
            end
          end
        end
        ST_DATA: begin
`ifndef PROG_LOADER_CHKSUM_EN
          if (flush_q) begin
            flush_q   <= 1'b0;
            state_q   <= ST_DONE;
            cpu_rst_o <= 1'b0;
            done_o    <= 1'b1;
          end else
`endif
          if (accept) begin
            mem_wen_o  <= 1'b1;
            mem_addr_o <= cnt_q;
            mem_data_o <= data_i;
            if (last_byte) begin
`ifdef PROG_LOADER_CHKSUM_EN
              state_q <= ST_CHK;
`else
              ready_o <= 1'b0;
              flush_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
`ifdef PROG_LOADER_CHKSUM_EN
        ST_CHK: begin
          if (accept) begin
            ready_o <= 1'b0;
            if (sum_match) begin
              state_q   <= ST_DONE;
              cpu_rst_o <= 1'b0;
              done_o    <= 1'b1;
            end else begin
              state_q <= ST_ERR;
              err_o   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
